// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-domain reset sequencer with programmable pre/assert/stagger timing
// Optional heartbeat pulse generator enabled by RESET_SEQ_HEARTBEAT_EN.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int CNT_W       = 16,
    parameter int HB_PERIOD   = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CNT_W-1:0]       pre_cycles,
    input  logic [CNT_W-1:0]       assert_cycles,
    input  logic [CNT_W-1:0]       stagger_cycles,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   busy,
    output logic                   done,
    output logic                   heartbeat
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        ASSERT  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]       ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]       ZERO     = '0;
    localparam logic [NUM_DOMAINS-1:0] ALL_ONES = '1;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [CNT_W-1:0]       pre_q, pre_d;
    logic [CNT_W-1:0]       assert_q, assert_d;
    logic [CNT_W-1:0]       stagger_q, stagger_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                   start_ok;

    // Assert length of zero is promoted to one so ASSERT is never skipped.
    logic [CNT_W-1:0] assert_eff;
    assign assert_eff = (assert_cycles == ZERO) ? ONE : assert_cycles;

    assign start_ok = start && !abort && (state == IDLE || state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pre_q     <= '0;
            assert_q  <= '0;
            stagger_q <= '0;
            rst_q     <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            pre_q     <= pre_d;
            assert_q  <= assert_d;
            stagger_q <= stagger_d;
            rst_q     <= rst_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        pre_d     = pre_q;
        assert_d  = assert_q;
        stagger_d = stagger_q;
        rst_d     = rst_q;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            rst_d   = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        pre_d     = pre_cycles;
                        assert_d  = assert_eff;
                        stagger_d = stagger_cycles;
                        cnt_d     = '0;
                        if (pre_cycles == ZERO) begin
                            state_d = ASSERT;
                            rst_d   = ALL_ONES;
                        end else begin
                            state_d = PRE;
                            rst_d   = '0;
                        end
                    end
                end
                PRE: begin
                    if (cnt == pre_q - ONE) begin
                        state_d = ASSERT;
                        cnt_d   = '0;
                        rst_d   = ALL_ONES;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
                ASSERT: begin
                    if (cnt == assert_q - ONE) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        // Domain 0 drops on entry; zero stagger drops everything together.
                        rst_d   = (stagger_q == ZERO) ? '0 : (ALL_ONES << 1);
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
                RELEASE: begin
                    if (rst_q == '0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else if (cnt == stagger_q - ONE) begin
                        // Shifting left frees the next-higher domain; cnt restarts per gap.
                        rst_d = rst_q << 1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rst_d   = '0;
                end
            endcase
        end
    end

    assign rst_out = rst_q;
    assign busy    = (state == PRE) || (state == ASSERT) || (state == RELEASE);
    assign done    = (state == DONE);

`ifdef RESET_SEQ_HEARTBEAT_EN
    localparam int HB_W = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_PERIOD - 1);

    logic [HB_W-1:0] hb_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_cnt <= '0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

    assign heartbeat = (hb_cnt == HB_LAST);
`else
    assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
// Heartbeat checks follow RESET_SEQ_HEARTBEAT_EN.
module tb_reset_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] pre_cycles;
    logic [15:0] assert_cycles;
    logic [15:0] stagger_cycles;
    logic [3:0]  rst_out;
    logic        busy;
    logic        done;
    logic        heartbeat;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] cap_rst  [0:23];
    logic       cap_busy [0:23];
    logic       cap_done [0:23];

    reset_sequencer #(.NUM_DOMAINS(4), .CNT_W(16), .HB_PERIOD(100)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .pre_cycles     (pre_cycles),
        .assert_cycles  (assert_cycles),
        .stagger_cycles (stagger_cycles),
        .rst_out        (rst_out),
        .busy           (busy),
        .done           (done),
        .heartbeat      (heartbeat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Cycle n holds the values seen after the n-th edge following the start request.
    task automatic run_seq(input int p, input int a, input int s, input int rep);
        pre_cycles     = 16'(p);
        assert_cycles  = 16'(a);
        stagger_cycles = 16'(s);
        start = 1'b1;
        for (int n = 1; n <= 23; n++) begin
            cycle();
            start = (n == rep);
            if (n == 1) begin
                pre_cycles     = 16'd7;
                assert_cycles  = 16'd9;
                stagger_cycles = 16'd5;
            end
            cap_rst[n]  = rst_out;
            cap_busy[n] = busy;
            cap_done[n] = done;
        end
        start = 1'b0;
    endtask

    task automatic check_ex1(input string tag);
        check({tag, " pre rst"},   32'(cap_rst[3]), 32'h0);
        check({tag, " pre busy"},  32'(cap_busy[1]), 32'h1);
        check({tag, " pre done"},  32'(cap_done[1]), 32'h0);
        for (int n = 4; n <= 6; n++) check({tag, " assert rst"}, 32'(cap_rst[n]), 32'hF);
        check({tag, " rel rst"},   32'(cap_rst[7]), 32'h0);
        check({tag, " rel busy"},  32'(cap_busy[7]), 32'h1);
        check({tag, " rel done"},  32'(cap_done[7]), 32'h0);
        check({tag, " done"},      32'(cap_done[8]), 32'h1);
        check({tag, " done busy"}, 32'(cap_busy[8]), 32'h0);
        check({tag, " done hold"}, 32'(cap_done[20]), 32'h1);
    endtask

    task automatic check_ex2(input string tag);
        check({tag, " rst1"},  32'(cap_rst[1]), 32'hF);
        check({tag, " rst2"},  32'(cap_rst[2]), 32'hE);
        check({tag, " rst3"},  32'(cap_rst[3]), 32'hE);
        check({tag, " rst4"},  32'(cap_rst[4]), 32'hC);
        check({tag, " rst6"},  32'(cap_rst[6]), 32'h8);
        check({tag, " rst7"},  32'(cap_rst[7]), 32'h8);
        check({tag, " rst8"},  32'(cap_rst[8]), 32'h0);
        check({tag, " busy8"}, 32'(cap_busy[8]), 32'h1);
        check({tag, " done8"}, 32'(cap_done[8]), 32'h0);
        check({tag, " done9"}, 32'(cap_done[9]), 32'h1);
        check({tag, " busy9"}, 32'(cap_busy[9]), 32'h0);
    endtask

    initial begin
        int hb_ones;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pre_cycles = '0;
        assert_cycles = '0;
        stagger_cycles = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset rst_out", 32'(rst_out), 32'h0);
        check("reset busy",    32'(busy), 32'h0);
        check("reset done",    32'(done), 32'h0);
        check("reset hb",      32'(heartbeat), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Idle window after reset also covers the heartbeat schedule.
        hb_ones = 0;
        for (int n = 1; n <= 300; n++) begin
            cycle();
            if (n <= 10) begin
                check("idle rst_out", 32'(rst_out), 32'h0);
                check("idle busy",    32'(busy), 32'h0);
                check("idle done",    32'(done), 32'h0);
            end
            if (heartbeat) hb_ones++;
`ifdef RESET_SEQ_HEARTBEAT_EN
            if (n == 99 || n == 199 || n == 299) check("hb pulse", 32'(heartbeat), 32'h1);
            if (n == 98 || n == 100 || n == 200) check("hb quiet", 32'(heartbeat), 32'h0);
`endif
        end
`ifdef RESET_SEQ_HEARTBEAT_EN
        check("hb count", 32'(hb_ones), 32'd3);
`else
        check("hb count", 32'(hb_ones), 32'd0);
`endif

        run_seq(3, 3, 0, 0);
        check_ex1("ex1");

        run_seq(0, 0, 2, 0);
        check_ex2("ex2");

        run_seq(3, 3, 0, 2);
        check_ex1("repulse");

        // Abort during ASSERT with a simultaneous start.
        pre_cycles = 16'd1;
        assert_cycles = 16'd5;
        stagger_cycles = 16'd1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("abort pre-state rst", 32'(rst_out), 32'hF);
        abort = 1'b1;
        start = 1'b1;
        cycle();
        abort = 1'b0;
        start = 1'b0;
        check("abort rst",  32'(rst_out), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort done", 32'(done), 32'h0);
        cycle();
        check("abort start dropped", 32'(busy), 32'h0);
        run_seq(0, 0, 2, 0);
        check_ex2("post-abort");

        // Asynchronous reset mid-run clears outputs without waiting for a clock edge.
        pre_cycles = 16'd0;
        assert_cycles = 16'd4;
        stagger_cycles = 16'd3;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("midrun rst before", 32'(rst_out), 32'hF);
        #2;
        reset = 1'b1;
        #1;
        check("midrun rst_out", 32'(rst_out), 32'h0);
        check("midrun busy",    32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cycle();
        check("midrun idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
